keypad_scanner: RTL and testbench

- Matrix-keypad front end: drives the 4 column lines, samples the 5 row lines, debounces, and emits one registered key code with a single-cycle press strobe.
- Sits directly upstream of the timer control logic inside timer_top, replacing raw row/column handling.
- The board-level key_pad matrix connects to o_key_out (columns) and i_key_in (rows).

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: rotates a one-hot column drive, samples the
// synchronized row lines at the end of each column slot, folds the samples of
// a full 4-column frame into one code (lowest code wins), and accepts a code
// change only after DEBOUNCE_FRAMES consecutive identical frames.
//
// Output strobes: o_key_valid and o_key_release are single-cycle pulses with no
// ready/backpressure. A pulse is only issued the cycle after a frame end, so
// two pulses are always at least one frame apart. o_key_code and o_key_held
// update in the same cycle as the pulse.
module keypad_scanner #(
  parameter int SCAN_DIV        = 2500,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_key_in,
  output logic [3:0] o_key_out,
  output logic [4:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_release,
  output logic       o_key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_FRAMES);

  logic [4:0]        sync1_q, sync2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [4:0]        acc_q, acc_d;
  logic [4:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              frame_end_q;
  logic [4:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              release_q, release_d;
  logic              held_q, held_d;

  logic       sample;
  logic       frame_end;
  logic       accept;
  logic [4:0] col_code;
  logic [4:0] frame_code;

  // Rows only move while their column is driven, so sampling on the last slot
  // cycle leaves settle time plus two synchronizer stages.
  assign sample    = (slot_q == SLOT_LAST);
  assign frame_end = sample && (col_q == 2'd3);
  assign accept    = frame_end_q && (stab_q == STAB_MAX) && (cand_q != code_q);

  assign o_key_out     = 4'b0001 << col_q;
  assign o_key_code    = code_q;
  assign o_key_valid   = valid_q;
  assign o_key_release = release_q;
  assign o_key_held    = held_q;

  // Code of the lowest closed row in the current column (0 when none).
  always_comb begin
    col_code = 5'd0;
    for (int r = 4; r >= 0; r--) begin
      if (sync2_q[r]) col_code = 5'(r * 4) + {3'b000, col_q} + 5'd1;
    end
  end

  // Merge this column into the frame so far, keeping the lowest nonzero code.
  always_comb begin
    frame_code = acc_q;
    if (col_code != 5'd0 && (acc_q == 5'd0 || col_code < acc_q)) frame_code = col_code;
  end

  // Next-state for scan, frame accumulation, debounce and acceptance.
  always_comb begin
    slot_d    = slot_q + 1'b1;
    col_d     = col_q;
    acc_d     = acc_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    held_d    = held_q;
    if (sample) begin
      slot_d = '0;
      col_d  = col_q + 2'd1;
      acc_d  = frame_code;
    end
    if (frame_end) begin
      acc_d = 5'd0;
      if (frame_code == cand_q) begin
        if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
      end else begin
        cand_d = frame_code;
        stab_d = STAB_W'(1);
      end
    end
    if (accept) begin
      code_d    = cand_q;
      valid_d   = (cand_q != 5'd0);
      release_d = (cand_q == 5'd0);
      held_d    = (cand_q != 5'd0);
    end
  end

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= i_key_in;
      sync2_q <= sync1_q;
    end
  end

  // State registers; reset discards any partial scan or debounce progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q      <= '0;
      col_q       <= 2'd0;
      acc_q       <= 5'd0;
      cand_q      <= 5'd0;
      stab_q      <= '0;
      frame_end_q <= 1'b0;
      code_q      <= 5'd0;
      valid_q     <= 1'b0;
      release_q   <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      frame_end_q <= frame_end;
      code_q      <= code_d;
      valid_q     <= valid_d;
      release_q   <= release_d;
      held_q      <= held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frame).
// A matrix model closes row r while column c is driven for each pressed key.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SD;

  logic       clk;
  logic       rst;
  logic [4:0] key_in;
  logic [3:0] key_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  logic [20:0] mask;       // mask[k]=1 : key with code k is closed
  int          cyc;        // cycle index since reset deassert
  int          n_checks;
  int          n_fail;
  logic [5:0]  exp_q[$];   // {is_release, code}
  logic        prev_pulse;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_in     (key_in),
    .o_key_out    (key_out),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .o_key_release(key_release),
    .o_key_held   (key_held)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Keypad matrix model
  always_comb begin
    key_in = 5'd0;
    for (int k = 1; k <= 20; k++) begin
      if (mask[k] && key_out[(k - 1) % 4]) key_in[(k - 1) / 4] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: column rotation model and pulse scoreboard
  always @(negedge clk) begin
    logic [3:0] exp_col;
    logic [5:0] e;
    if (!rst) begin
      exp_col = 4'b0001 << ((cyc / SD) % 4);
      check("column_drive", {28'd0, key_out}, {28'd0, exp_col});
      if (key_valid && key_release) check("valid_and_release_same_cycle", 32'd1, 32'd0);
      if (key_valid || key_release) begin
        if (prev_pulse) check("consecutive_pulses", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {26'd0, key_release, key_code}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_event", {26'd0, key_release, key_code}, {26'd0, e});
          check("held_level", {31'd0, key_held}, {31'd0, ~e[5]});
        end
      end
      prev_pulse = key_valid || key_release;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_frame_start();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((cyc % FRAME) != 0 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wait_pulse(input bit want_release, input int bound, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (want_release ? key_release : key_valid) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check(want_release ? "release_seen" : "valid_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic count_pulses(input int n, output int nv, output int nr);
    nv = 0;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid)   nv++;
      if (key_release) nr++;
    end
  endtask

  initial begin
    int f, t, r, nv, nr;
    n_checks   = 0;
    n_fail     = 0;
    mask       = '0;
    prev_pulse = 1'b0;
    rst        = 1'b1;

    // Reset values
    step(3);
    #1;
    check("rst_key_out", {28'd0, key_out}, 32'd1);
    check("rst_code", {27'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_release", {31'd0, key_release}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: no pulses, code stays 0
    count_pulses(100, nv, nr);
    check("idle_valid_count", nv, 0);
    check("idle_release_count", nr, 0);
    check("idle_code", {27'd0, key_code}, 32'd0);
    check("idle_held", {31'd0, key_held}, 32'd0);

    // Hold code 12 (row 2, col 3) from a frame start
    wait_frame_start();
    f = cyc;
    mask[12] = 1'b1;
    exp_q.push_back({1'b0, 5'd12});
    wait_pulse(1'b0, 100, t);
    check("press12_latency", t - f, DF * FRAME + 1);
    check("press12_code", {27'd0, key_code}, 32'd12);
    check("press12_held", {31'd0, key_held}, 32'd1);
    count_pulses(10 * FRAME, nv, nr);
    check("hold12_no_repeat", nv, 0);

    // Release code 12
    r = cyc;
    mask[12] = 1'b0;
    exp_q.push_back({1'b1, 5'd0});
    wait_pulse(1'b1, 100, t);
    check("release12_in_window", {31'd0, (t - r >= 48) && (t - r <= 64)}, 32'd1);
    check("release12_code", {27'd0, key_code}, 32'd0);
    check("release12_held", {31'd0, key_held}, 32'd0);

    // Two-frame glitch of code 1 is rejected
    wait_frame_start();
    mask[1] = 1'b1;
    count_pulses(2 * FRAME, nv, nr);
    mask[1] = 1'b0;
    count_pulses(4 * FRAME, t, r);
    check("glitch1_no_valid", nv + t, 0);
    check("glitch1_code", {27'd0, key_code}, 32'd0);

    // Codes 2 and 7 together: lowest wins
    wait_frame_start();
    f = cyc;
    mask[2] = 1'b1;
    mask[7] = 1'b1;
    exp_q.push_back({1'b0, 5'd2});
    wait_pulse(1'b0, 100, t);
    check("dual_latency", t - f, DF * FRAME + 1);
    check("dual_code", {27'd0, key_code}, 32'd2);

    // Release 2 while holding 7: straight to 7, no release pulse
    mask[2] = 1'b0;
    exp_q.push_back({1'b0, 5'd7});
    wait_pulse(1'b0, 100, t);
    check("switch7_code", {27'd0, key_code}, 32'd7);
    check("switch7_held", {31'd0, key_held}, 32'd1);

    // Swap 7 for 12, reset while code 12 is two frames into debounce
    wait_frame_start();
    mask[7]  = 1'b0;
    mask[12] = 1'b1;
    step(2 * FRAME + 8);
    check("pre_rst_code", {27'd0, key_code}, 32'd7);
    rst = 1'b1;
    #1;
    check("midrst_key_out", {28'd0, key_out}, 32'd1);
    check("midrst_code", {27'd0, key_code}, 32'd0);
    check("midrst_held", {31'd0, key_held}, 32'd0);
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    step(3);
    rst = 1'b0;
    exp_q.push_back({1'b0, 5'd12});
    wait_pulse(1'b0, 100, t);
    check("post_rst_latency", t, DF * FRAME + 1);
    check("post_rst_code", {27'd0, key_code}, 32'd12);

    mask[12] = 1'b0;
    exp_q.push_back({1'b1, 5'd0});
    wait_pulse(1'b1, 100, t);
    check("final_code", {27'd0, key_code}, 32'd0);
    step(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
